// File: rtl/gmii_udp_rx_demux_pkg.sv
// Shared definitions for the GMII UDP receiver: header byte offsets (preamble
// included), protocol constants and FSM state encoding.
package gmii_udp_rx_demux_pkg;

  localparam int CNT_W = 11;

  localparam logic [CNT_W-1:0] OFS_ETYPE   = 11'd20;
  localparam logic [CNT_W-1:0] OFS_VER_IHL = 11'd22;
  localparam logic [CNT_W-1:0] OFS_PROTO   = 11'd31;
  localparam logic [CNT_W-1:0] OFS_DIP     = 11'd38;
  localparam logic [CNT_W-1:0] OFS_DPORT   = 11'd44;
  localparam logic [CNT_W-1:0] OFS_ULEN    = 11'd46;
  localparam logic [CNT_W-1:0] OFS_PAYLOAD = 11'd50;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  PROTO_UDP      = 8'h11;
  localparam int          UDP_HDR_LEN    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LHDR,
    ST_DATA,
    ST_DROP
  } state_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gmii_udp_rx_demux_byte_packer.sv
// Packs payload bytes MSB-first into DATA_BYTES-wide words; a final (or
// aborting) request flushes whatever is held as a zero-padded last word.
module gmii_byte_packer #(
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk125,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [7:0]              din,
  input  logic                    fin,
  input  logic                    err,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [DATA_BYTES-1:0]   o_keep,
  output logic                    o_valid,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic                    o_err
);

  localparam int LW = $clog2(DATA_BYTES + 1);

  logic [8*DATA_BYTES-1:0] acc, acc_nxt;
  logic [LW-1:0]           lanes, lanes_nxt;
  logic [DATA_BYTES-1:0]   keep_nxt;
  logic                    first;
  logic                    emit;

  always_comb begin
    acc_nxt   = acc;
    lanes_nxt = lanes;
    if (push) begin
      for (int i = 0; i < DATA_BYTES; i++)
        if (lanes == LW'(i)) acc_nxt[8*(DATA_BYTES-1-i) +: 8] = din;
      lanes_nxt = lanes + 1'b1;
    end
    emit     = fin || (lanes_nxt == LW'(DATA_BYTES));
    keep_nxt = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      keep_nxt[DATA_BYTES-1-i] = (LW'(i) < lanes_nxt);
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      lanes   <= '0;
      first   <= 1'b1;
      o_data  <= '0;
      o_keep  <= '0;
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= emit;
      o_sop   <= emit & first;
      o_eop   <= emit & fin;
      o_err   <= emit & fin & err;
      if (emit) begin
        o_data <= acc_nxt;
        o_keep <= keep_nxt;
        acc    <= '0;
        lanes  <= '0;
        // the word after a final word starts a new packet
        first  <= fin;
      end else begin
        acc   <= acc_nxt;
        lanes <= lanes_nxt;
      end
    end
  end

endmodule

// File: rtl/gmii_udp_rx_demux.sv
// GMII UDP receiver: parses Ethernet/IPv4/UDP headers, accepts NUM_CH ports,
// strips the line header and hands payload bytes to the word packer.
//  state | meaning
//  IDLE  | waiting for rx_dv
//  HDR   | capturing header fields, evaluated on byte 49
//  LHDR  | capturing HDR_BYTES line-header bytes
//  DATA  | forwarding R payload bytes to the packer
//  DROP  | ignoring the rest of the frame until rx_dv falls
module gmii_udp_rx_demux
  import gmii_udp_rx_demux_pkg::*;
#(
  parameter logic [31:0] IPV4_DST    = 32'hC0A80001,
  parameter logic [15:0] PORT_BASE   = 16'd12345,
  parameter int          NUM_CH      = 2,
  parameter int          DATA_BYTES  = 2,
  parameter int          HDR_BYTES   = 2,
  parameter int          MAX_PAYLOAD = 1472,
  localparam int         CH_W        = ch_width(NUM_CH)
) (
  input  logic                    clk125,
  input  logic                    sys_rst_n,
  input  logic                    id,
  input  logic [7:0]              rxd,
  input  logic                    rx_dv,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [DATA_BYTES-1:0]   o_keep,
  output logic                    o_valid,
  output logic                    o_sop,
  output logic                    o_eop,
  output logic                    o_err,
  output logic [CH_W-1:0]         o_ch,
  output logic [15:0]             o_hdr,
  output logic                    o_busy,
  output logic [15:0]             o_ok_cnt,
  output logic [15:0]             o_drop_cnt
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      etype, dport, ulen;
  logic [7:0]       ver_ihl, proto;
  logic [31:0]      dip;
  logic [10:0]      rem;
  logic [1:0]       hdr_idx;
  logic             pk_push, pk_fin, pk_err;

  logic [31:0]   my_ip;
  logic [16:0]   port_lo, port_hi;
  logic          ip_match, port_ok, len_ok, eval;
  logic [10:0]   r_len;
  logic [CH_W-1:0] ch_off;

  assign my_ip    = IPV4_DST + {31'd0, id};
  assign ip_match = (etype == ETHERTYPE_IPV4) && (ver_ihl == IPV4_VER_IHL) &&
                    (proto == PROTO_UDP) && (dip == my_ip);
  assign port_lo  = {1'b0, PORT_BASE};
  assign port_hi  = port_lo + 17'(NUM_CH);
  assign port_ok  = ({1'b0, dport} >= port_lo) && ({1'b0, dport} < port_hi);
  assign len_ok   = ({1'b0, ulen} >= 17'(UDP_HDR_LEN + HDR_BYTES)) &&
                    ({1'b0, ulen} <= 17'(UDP_HDR_LEN + MAX_PAYLOAD));
  // decide on byte 49 so that byte 50 is already consumed by LHDR/DATA
  assign eval     = (state == ST_HDR) && rx_dv && (cnt == OFS_PAYLOAD - 11'd1);
  assign r_len    = 11'(ulen - 16'(UDP_HDR_LEN + HDR_BYTES));
  assign ch_off   = CH_W'(dport - PORT_BASE);

  always_comb begin
    pk_push = 1'b0;
    pk_fin  = 1'b0;
    pk_err  = 1'b0;
    case (state)
      ST_LHDR: if (!rx_dv) begin
        pk_fin = 1'b1;
        pk_err = 1'b1;
      end
      ST_DATA: begin
        if (rem == 11'd0) begin
          pk_fin = 1'b1;
        end else if (rx_dv) begin
          pk_push = 1'b1;
          pk_fin  = (rem == 11'd1);
        end else begin
          pk_fin = 1'b1;
          pk_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      etype      <= '0;
      dport      <= '0;
      ulen       <= '0;
      ver_ihl    <= '0;
      proto      <= '0;
      dip        <= '0;
      rem        <= '0;
      hdr_idx    <= '0;
      o_ch       <= '0;
      o_hdr      <= '0;
      o_busy     <= 1'b0;
      o_ok_cnt   <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (!rx_dv)                cnt <= '0;
      else if (cnt != 11'h7FF)   cnt <= cnt + 11'd1;

      if (rx_dv && state == ST_HDR) begin
        if (cnt == OFS_ETYPE || cnt == OFS_ETYPE + 11'd1) etype <= {etype[7:0], rxd};
        if (cnt == OFS_VER_IHL) ver_ihl <= rxd;
        if (cnt == OFS_PROTO)   proto   <= rxd;
        if (cnt >= OFS_DIP && cnt <= OFS_DIP + 11'd3) dip <= {dip[23:0], rxd};
        if (cnt == OFS_DPORT || cnt == OFS_DPORT + 11'd1) dport <= {dport[7:0], rxd};
        if (cnt == OFS_ULEN || cnt == OFS_ULEN + 11'd1)   ulen  <= {ulen[7:0], rxd};
      end

      case (state)
        ST_IDLE: begin
          o_busy <= 1'b0;
          if (rx_dv) state <= ST_HDR;
        end
        ST_HDR: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (eval) begin
            if (ip_match && port_ok && len_ok) begin
              state   <= (HDR_BYTES == 0) ? ST_DATA : ST_LHDR;
              o_busy  <= 1'b1;
              o_ch    <= ch_off;
              o_hdr   <= '0;
              hdr_idx <= '0;
              rem     <= r_len;
            end else begin
              state <= ST_DROP;
              if (ip_match) o_drop_cnt <= o_drop_cnt + 16'd1;
            end
          end
        end
        ST_LHDR: begin
          if (!rx_dv) begin
            state      <= ST_IDLE;
            o_busy     <= 1'b0;
            o_drop_cnt <= o_drop_cnt + 16'd1;
          end else begin
            if (hdr_idx == 2'd0) o_hdr[7:0]  <= rxd;
            else                 o_hdr[15:8] <= rxd;
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'(HDR_BYTES - 1)) state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (pk_push) rem <= rem - 11'd1;
          if (pk_fin) begin
            o_busy <= 1'b0;
            state  <= rx_dv ? ST_DROP : ST_IDLE;
            if (pk_err) o_drop_cnt <= o_drop_cnt + 16'd1;
            else        o_ok_cnt   <= o_ok_cnt + 16'd1;
          end
        end
        ST_DROP: begin
          o_busy <= 1'b0;
          if (!rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  gmii_byte_packer #(.DATA_BYTES(DATA_BYTES)) u_packer (
    .clk125  (clk125),
    .rst_n   (sys_rst_n),
    .push    (pk_push),
    .din     (rxd),
    .fin     (pk_fin),
    .err     (pk_err),
    .o_data  (o_data),
    .o_keep  (o_keep),
    .o_valid (o_valid),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
    .o_err   (o_err)
  );

endmodule

// File: tb/tb_gmii_udp_rx_demux.sv
// Directed bench: two receivers (4 ch x 2-byte words, 2 ch x 4-byte words)
// share one GMII stream; frame vectors carry hand-computed word expectations.
module tb_gmii_udp_rx_demux;

  logic       clk125 = 1'b0;
  logic       sys_rst_n;
  logic       id;
  logic [7:0] rxd;
  logic       rx_dv;

  always #4 clk125 = ~clk125;

  logic [15:0] a_data;  logic [1:0] a_keep; logic [1:0] a_ch;
  logic a_valid, a_sop, a_eop, a_err, a_busy;
  logic [15:0] a_hdr, a_ok, a_drop;
  logic [31:0] b_data;  logic [3:0] b_keep; logic [0:0] b_ch;
  logic b_valid, b_sop, b_eop, b_err, b_busy;
  logic [15:0] b_hdr, b_ok, b_drop;

  gmii_udp_rx_demux #(.NUM_CH(4), .DATA_BYTES(2), .HDR_BYTES(2)) u_a (
    .clk125(clk125), .sys_rst_n(sys_rst_n), .id(id), .rxd(rxd), .rx_dv(rx_dv),
    .o_data(a_data), .o_keep(a_keep), .o_valid(a_valid), .o_sop(a_sop),
    .o_eop(a_eop), .o_err(a_err), .o_ch(a_ch), .o_hdr(a_hdr), .o_busy(a_busy),
    .o_ok_cnt(a_ok), .o_drop_cnt(a_drop));

  gmii_udp_rx_demux #(.NUM_CH(2), .DATA_BYTES(4), .HDR_BYTES(2)) u_b (
    .clk125(clk125), .sys_rst_n(sys_rst_n), .id(id), .rxd(rxd), .rx_dv(rx_dv),
    .o_data(b_data), .o_keep(b_keep), .o_valid(b_valid), .o_sop(b_sop),
    .o_eop(b_eop), .o_err(b_err), .o_ch(b_ch), .o_hdr(b_hdr), .o_busy(b_busy),
    .o_ok_cnt(b_ok), .o_drop_cnt(b_drop));

  typedef struct {
    logic [31:0] data; logic [3:0] keep; logic sop, eop, err;
    logic [3:0] ch; logic [15:0] hdr;
  } word_t;

  word_t qa[$];
  word_t qb[$];

  always @(negedge clk125) begin
    if (a_valid) qa.push_back('{{16'd0, a_data}, {2'd0, a_keep}, a_sop, a_eop, a_err, {2'd0, a_ch}, a_hdr});
    if (b_valid) qb.push_back('{b_data, b_keep, b_sop, b_eop, b_err, {3'd0, b_ch}, b_hdr});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] etype, input logic [7:0] ip_lo,
                            input logic [15:0] port, input logic [15:0] ulen,
                            input int npay, input int rst_at);
    logic [7:0] f[$];
    f = {};
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    repeat (6) f.push_back(8'h02);
    repeat (6) f.push_back(8'h04);
    f.push_back(etype[15:8]); f.push_back(etype[7:0]);
    f.push_back(8'h45); f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h2E);
    f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
    f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h00); f.push_back(8'h0A);
    f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h00); f.push_back(ip_lo);
    f.push_back(8'h30); f.push_back(8'h39);
    f.push_back(port[15:8]); f.push_back(port[7:0]);
    f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < npay; i++)
      f.push_back(i == 0 ? 8'h23 : i == 1 ? 8'h01 : 8'(8'hA1 + i - 2));
    if (npay == int'(ulen) - 8) begin
      f.push_back(8'hDE); f.push_back(8'hAD); f.push_back(8'hBE); f.push_back(8'hEF);
    end
    for (int k = 0; k < f.size(); k++) begin
      @(negedge clk125);
      if (k == rst_at) begin
        chk("busy_before_rst", {31'd0, a_busy}, 32'd1);
        sys_rst_n = 1'b0;
        rx_dv = 1'b0;
        rxd = 8'h00;
        #1;
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_ok_cnt", {16'd0, a_ok}, 32'd0);
        chk("rst_drop_cnt", {16'd0, a_drop}, 32'd0);
        chk("rst_word_outs", {10'd0, a_valid, a_sop, a_eop, a_err, a_keep, a_data}, 32'd0);
        chk("rst_hdr_ch", {14'd0, a_ch, a_hdr}, 32'd0);
        #1 sys_rst_n = 1'b1;
        break;
      end
      rxd = f[k];
      rx_dv = 1'b1;
    end
    @(negedge clk125);
    rx_dv = 1'b0;
    rxd = 8'h00;
    repeat (6) @(negedge clk125);
  endtask

  typedef struct {
    logic [15:0] etype; logic [7:0] ip_lo; logic idv; logic [15:0] port; logic [15:0] ulen;
    int npay; int nw; logic [31:0] first_d; logic [31:0] last_d; logic [3:0] last_k;
    logic last_err; logic [3:0] ch; logic [15:0] hdr; logic hdr_chk; int ok_d; int drop_d;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ok0, dr0;
    word_t w;

    //                etype    ip     id   port       ulen      npay nw first      last       keep err  ch    hdr       chk  ok dr
    vecs[0]  = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd18,   10, 4, 32'hA1A2, 32'hA7A8, 4'h3, 1'b0, 4'd0, 16'h0123, 1'b1, 1, 0};
    vecs[1]  = '{16'h0800, 8'h01, 1'b0, 16'd12348, 16'd18,   10, 4, 32'hA1A2, 32'hA7A8, 4'h3, 1'b0, 4'd3, 16'h0123, 1'b1, 1, 0};
    vecs[2]  = '{16'h0800, 8'h01, 1'b0, 16'd12349, 16'd18,   10, 0, 32'h0,    32'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0, 0, 1};
    vecs[3]  = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd17,    9, 4, 32'hA1A2, 32'hA700, 4'h2, 1'b0, 4'd0, 16'h0123, 1'b1, 1, 0};
    vecs[4]  = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd26,    7, 3, 32'hA1A2, 32'hA500, 4'h2, 1'b1, 4'd0, 16'h0123, 1'b1, 0, 1};
    vecs[5]  = '{16'h0800, 8'h01, 1'b0, 16'd12346, 16'd10,    2, 1, 32'h0,    32'h0,    4'h0, 1'b0, 4'd1, 16'h0123, 1'b1, 1, 0};
    vecs[6]  = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd1481,  4, 0, 32'h0,    32'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0, 0, 1};
    vecs[7]  = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd9,     1, 0, 32'h0,    32'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0, 0, 1};
    vecs[8]  = '{16'h86DD, 8'h01, 1'b0, 16'd12345, 16'd18,   10, 0, 32'h0,    32'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0, 0, 0};
    vecs[9]  = '{16'h0800, 8'h02, 1'b1, 16'd12347, 16'd18,   10, 4, 32'hA1A2, 32'hA7A8, 4'h3, 1'b0, 4'd2, 16'h0123, 1'b1, 1, 0};
    vecs[10] = '{16'h0800, 8'h01, 1'b1, 16'd12345, 16'd18,   10, 0, 32'h0,    32'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0, 0, 0};
    vecs[11] = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd18,    1, 1, 32'h0,    32'h0,    4'h0, 1'b1, 4'd0, 16'h0,    1'b0, 0, 1};
    vecs[12] = '{16'h0800, 8'h01, 1'b0, 16'd12345, 16'd1480, 12, 6, 32'hA1A2, 32'h0,    4'h0, 1'b1, 4'd0, 16'h0123, 1'b1, 0, 1};
    vecs[13] = '{16'h0800, 8'h05, 1'b0, 16'd12349, 16'd18,   10, 0, 32'h0,    32'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0, 0, 0};

    sys_rst_n = 1'b0;
    id = 1'b0;
    rxd = 8'h00;
    rx_dv = 1'b0;
    repeat (3) @(negedge clk125);
    chk("reset_busy", {31'd0, a_busy}, 32'd0);
    chk("reset_counters", {a_ok, a_drop}, 32'd0);
    chk("reset_word_outs", {10'd0, a_valid, a_sop, a_eop, a_err, a_keep, a_data}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk125);

    for (int i = 0; i < NV; i++) begin
      id = vecs[i].idv;
      ok0 = a_ok;
      dr0 = a_drop;
      qa.delete();
      send_frame(vecs[i].etype, vecs[i].ip_lo, vecs[i].port, vecs[i].ulen, vecs[i].npay, -1);
      chk($sformatf("v%0d_ok_cnt", i), {16'd0, a_ok}, {16'd0, 16'(ok0 + 16'(vecs[i].ok_d))});
      chk($sformatf("v%0d_drop_cnt", i), {16'd0, a_drop}, {16'd0, 16'(dr0 + 16'(vecs[i].drop_d))});
      chk($sformatf("v%0d_nwords", i), 32'(qa.size()), 32'(vecs[i].nw));
      chk($sformatf("v%0d_busy_after", i), {31'd0, a_busy}, 32'd0);
      if (qa.size() == vecs[i].nw && vecs[i].nw > 0) begin
        for (int j = 0; j < vecs[i].nw; j++) begin
          w = qa[j];
          chk($sformatf("v%0d_w%0d_sop", i, j), {31'd0, w.sop}, {31'd0, j == 0});
          chk($sformatf("v%0d_w%0d_eop", i, j), {31'd0, w.eop}, {31'd0, j == vecs[i].nw - 1});
          chk($sformatf("v%0d_w%0d_err", i, j), {31'd0, w.err},
              {31'd0, (j == vecs[i].nw - 1) ? vecs[i].last_err : 1'b0});
          chk($sformatf("v%0d_w%0d_ch", i, j), {28'd0, w.ch}, {28'd0, vecs[i].ch});
          if (vecs[i].hdr_chk)
            chk($sformatf("v%0d_w%0d_hdr", i, j), {16'd0, w.hdr}, {16'd0, vecs[i].hdr});
        end
        chk($sformatf("v%0d_first_data", i), qa[0].data, vecs[i].first_d);
        chk($sformatf("v%0d_last_data", i), qa[vecs[i].nw-1].data, vecs[i].last_d);
        chk($sformatf("v%0d_last_keep", i), {28'd0, qa[vecs[i].nw-1].keep}, {28'd0, vecs[i].last_k});
      end
    end

    // 4-byte words, 7 payload bytes after the line header
    id = 1'b0;
    qb.delete();
    send_frame(16'h0800, 8'h01, 16'd12345, 16'd17, 9, -1);
    chk("b_nwords", 32'(qb.size()), 32'd2);
    if (qb.size() == 2) begin
      chk("b_w0_data", qb[0].data, 32'hA1A2A3A4);
      chk("b_w0_keep", {28'd0, qb[0].keep}, 32'hF);
      chk("b_w0_flags", {29'd0, qb[0].sop, qb[0].eop, qb[0].err}, 32'b100);
      chk("b_w1_data", qb[1].data, 32'hA5A6A700);
      chk("b_w1_keep", {28'd0, qb[1].keep}, 32'hE);
      chk("b_w1_flags", {29'd0, qb[1].sop, qb[1].eop, qb[1].err}, 32'b010);
      chk("b_hdr", {16'd0, qb[1].hdr}, 32'h0123);
    end

    // reset while the third data byte is on the wire, then a clean frame
    send_frame(16'h0800, 8'h01, 16'd12345, 16'd26, 18, 55);
    qa.delete();
    send_frame(16'h0800, 8'h01, 16'd12345, 16'd18, 10, -1);
    chk("post_rst_nwords", 32'(qa.size()), 32'd4);
    chk("post_rst_ok_cnt", {16'd0, a_ok}, 32'd1);
    chk("post_rst_drop_cnt", {16'd0, a_drop}, 32'd0);
    if (qa.size() == 4) begin
      chk("post_rst_first", qa[0].data, 32'hA1A2);
      chk("post_rst_last", qa[3].data, 32'hA7A8);
      chk("post_rst_eop", {30'd0, qa[0].eop, qa[3].eop}, 32'b01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
